data_cache: RTL and testbench
=============================

# data_cache

Direct-mapped, write-back, write-allocate data cache between the CPU load/store path and the byte-wide `Data_Memory`. CPU hits complete in the access cycle. Misses stall the CPU with `CPU_BUSYWAIT`, then perform block transfers using the memory's READ/WRITE/BUSYWAIT handshake:

- Dirty victim: write back 4 bytes.
- Refill: fetch 4 bytes.

## Interface
- No parameters. Geometry is fixed: 8 lines × 4 bytes. Address split: tag = `ADDR[7:5]`, index = `ADDR[4:2]`, offset = `ADDR[1:0]`.
- `CLK` input 1: clock. All state updates on the rising edge.
- `RESET` input 1: synchronous, active-high reset.
- `CPU_ADDRESS` input 8: byte address.
- `CPU_WRITEDATA` input 8: store data.
- `CPU_READ` input 1: load request, held until the access completes.
- `CPU_WRITE` input 1: store request, held until the access completes.
- `CPU_READDATA` output 8: load data.
- `CPU_BUSYWAIT` output 1: CPU stall.
- `MEM_ADDRESS` output 8: byte address to `Data_Memory`.
- `MEM_WRITEDATA` output 8: byte to `Data_Memory`.
- `MEM_READ` output 1: memory read request.
- `MEM_WRITE` output 1: memory write request.
- `MEM_READDATA` input 8: byte from `Data_Memory`.
- `MEM_BUSYWAIT` input 1: memory busy.
- `HIT_COUNT` output 8: present only with `DCACHE_STATS_EN`.
- `MISS_COUNT` output 8: present only with `DCACHE_STATS_EN`.

## Operation
- Per-line state: valid bit, dirty bit, 3-bit tag, 4 data bytes.
- `hit` = valid[index] & (tag[index] == `CPU_ADDRESS[7:5]`).
- `CPU_READ` and `CPU_WRITE` both high is illegal. It is treated as a write.
- FSM states: IDLE, WRITEBACK, FETCH, UPDATE.
- **IDLE, request and hit:**
  - Read: `CPU_READDATA` = line byte at offset (combinational).
  - Write: byte is written at the edge and dirty is set.
  - `CPU_BUSYWAIT` = 0.
- **IDLE, request and miss:**
  - Latch address and write data.
  - Go to WRITEBACK if the victim is valid and dirty, otherwise to FETCH.
  - Beat counter is set to 0.
- **WRITEBACK:**
  - 4 beats. `MEM_ADDRESS` = {victim tag, index, beat}. `MEM_WRITEDATA` = victim byte[beat].
  - After beat 3, go to FETCH.
- **FETCH:**
  - 4 beats. `MEM_ADDRESS` = {latched tag, index, beat}.
  - `MEM_READDATA` is written into line byte[beat] when the beat completes.
  - After beat 3, go to UPDATE.
- **UPDATE:** one cycle. Install tag, set valid = 1 and dirty = 0, return to IDLE. The held request then hits. A write hit sets dirty.
- **Beat handshake:**
  - Request (`MEM_READ` or `MEM_WRITE`) is asserted for the beat.
  - `MEM_BUSYWAIT` is ignored on the first edge after assertion.
  - The first later edge sampling `MEM_BUSYWAIT` = 0 completes the beat.
  - Request is then low for exactly one gap cycle, with the counter incremented, before the next beat.
  - `MEM_READ` and `MEM_WRITE` are never high together.
- **`CPU_BUSYWAIT`:** = (`CPU_READ` | `CPU_WRITE`) & ~(state == IDLE & hit). It is also 1 in every non-IDLE state.
- **Reset** (any state, including mid-transfer):
  - At the edge: all valid and dirty bits cleared, FSM to IDLE, beat counter to 0, `MEM_READ`/`MEM_WRITE` = 0.
  - A dirty line that is mid-writeback is discarded. This is by design.
  - Data arrays are not cleared.
- **Reset values:**
  - `MEM_READ` = `MEM_WRITE` = 0, `MEM_ADDRESS` = 0, `MEM_WRITEDATA` = 0.
  - `CPU_READDATA` = 0 when there is no read hit.
  - `CPU_BUSYWAIT` = 0 with no request.
  - Counters = 0.

## Timing
- Hit latency: 0 stall cycles. Read data is valid in the request cycle, and the write commits at the following edge.
- Beat length: N + 1 cycles, where N is the number of request cycles until `MEM_BUSYWAIT` is sampled low (N ≥ 2). The +1 is the gap cycle.
- Clean miss: 4(N+1) + 1 cycles of stall.
- Dirty miss: 8(N+1) + 1 cycles of stall.
- The CPU must hold its address and data while `CPU_BUSYWAIT` = 1. The cache uses latched copies throughout the transfer.

## Configuration
- `DCACHE_STATS_EN` defined:
  - `HIT_COUNT` increments on each IDLE hit that was not preceded by a refill for the same request.
  - `MISS_COUNT` increments on each IDLE → WRITEBACK/FETCH transition.
  - Both counters are 8-bit, saturate at 255, and clear on `RESET`.
- `DCACHE_STATS_EN` undefined: both ports and all counter logic are absent. Behaviour is otherwise identical.

## Test plan
- `RESET` then read 0x14: miss; 4 `MEM_READ` beats at 0x14–0x17; `MEM_WRITE` stays 0; `CPU_READDATA` = mem[0x14] once `CPU_BUSYWAIT` falls.
- Read 0x15: `CPU_BUSYWAIT` = 0 in the same cycle; data = mem[0x15]; no memory request.
- Write 0xAB to 0x16: hit; completes in one cycle; no `MEM_WRITE`; line 5 becomes dirty.
- Read 0xB4 (index 5, tag 5): 4 `MEM_WRITE` beats at 0x14–0x17 with 0xAB at 0x16, then 4 `MEM_READ` beats at 0xB4–0xB7; data = mem[0xB4].
- `RESET` during FETCH beat 2: at the next edge `MEM_READ` = 0 and FSM is IDLE; a subsequent read of 0xB4 misses again.
- With `DCACHE_STATS_EN`, after the first four scenarios: `HIT_COUNT` = 2, `MISS_COUNT` = 2.

Source files
------------

// File: rtl/data_cache_if.sv
// CPU-side and memory-side signal bundle for data_cache.
// HIT_COUNT/MISS_COUNT exist only when DCACHE_STATS_EN is defined.
interface data_cache_if;
    logic [7:0] CPU_ADDRESS;
    logic [7:0] CPU_WRITEDATA;
    logic       CPU_READ;
    logic       CPU_WRITE;
    logic [7:0] CPU_READDATA;
    logic       CPU_BUSYWAIT;
    logic [7:0] MEM_ADDRESS;
    logic [7:0] MEM_WRITEDATA;
    logic       MEM_READ;
    logic       MEM_WRITE;
    logic [7:0] MEM_READDATA;
    logic       MEM_BUSYWAIT;
`ifdef DCACHE_STATS_EN
    logic [7:0] HIT_COUNT;
    logic [7:0] MISS_COUNT;

    modport slave (
        input  CPU_ADDRESS, CPU_WRITEDATA, CPU_READ, CPU_WRITE, MEM_READDATA, MEM_BUSYWAIT,
        output CPU_READDATA, CPU_BUSYWAIT, MEM_ADDRESS, MEM_WRITEDATA, MEM_READ, MEM_WRITE,
        output HIT_COUNT, MISS_COUNT
    );
    modport master (
        output CPU_ADDRESS, CPU_WRITEDATA, CPU_READ, CPU_WRITE, MEM_READDATA, MEM_BUSYWAIT,
        input  CPU_READDATA, CPU_BUSYWAIT, MEM_ADDRESS, MEM_WRITEDATA, MEM_READ, MEM_WRITE,
        input  HIT_COUNT, MISS_COUNT
    );
`else
    modport slave (
        input  CPU_ADDRESS, CPU_WRITEDATA, CPU_READ, CPU_WRITE, MEM_READDATA, MEM_BUSYWAIT,
        output CPU_READDATA, CPU_BUSYWAIT, MEM_ADDRESS, MEM_WRITEDATA, MEM_READ, MEM_WRITE
    );
    modport master (
        output CPU_ADDRESS, CPU_WRITEDATA, CPU_READ, CPU_WRITE, MEM_READDATA, MEM_BUSYWAIT,
        input  CPU_READDATA, CPU_BUSYWAIT, MEM_ADDRESS, MEM_WRITEDATA, MEM_READ, MEM_WRITE
    );
`endif
endinterface

// File: rtl/data_cache.sv
// Direct-mapped write-back write-allocate cache, 8 lines x 4 bytes, byte-wide memory side.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module data_cache (
    input logic         CLK,
    input logic         RESET,
    data_cache_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StWriteback, StFetch, StUpdate} state_e;

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       gap_q, gap_d;
    logic       first_q, first_d;
    logic [7:0] valid_q, dirty_q;
    logic [2:0] tag_q [8];
    logic [7:0] data_q [8][4];
    logic [2:0] lat_tag_q, lat_index_q;
    logic [7:0] lat_wdata_q;
    logic       refilled_q;

    logic [2:0] index, tag_in;
    logic [1:0] offset;
    logic       req, hit, idle_hit, idle_miss, beat_done;
    logic       mem_read, mem_write;
    logic [7:0] mem_address, mem_writedata;

    assign index     = bus.CPU_ADDRESS[4:2];
    assign tag_in    = bus.CPU_ADDRESS[7:5];
    assign offset    = bus.CPU_ADDRESS[1:0];
    assign req       = bus.CPU_READ | bus.CPU_WRITE;
    assign hit       = valid_q[index] && (tag_q[index] == tag_in);
    assign idle_hit  = (state_q == StIdle) && req && hit;
    assign idle_miss = (state_q == StIdle) && req && !hit;
    // The first edge of each beat ignores MEM_BUSYWAIT; the memory needs a cycle to respond.
    assign beat_done = (mem_read || mem_write) && !first_q && !bus.MEM_BUSYWAIT;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        gap_d         = gap_q;
        first_d       = first_q;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = 8'h00;
        mem_writedata = 8'h00;
        case (state_q)
            StIdle: begin
                if (idle_miss) begin
                    cnt_d   = 2'd0;
                    gap_d   = 1'b0;
                    first_d = 1'b1;
                    state_d = (valid_q[index] && dirty_q[index]) ? StWriteback : StFetch;
                end
            end
            StWriteback, StFetch: begin
                if (state_q == StWriteback) begin
                    mem_write     = !gap_q;
                    mem_address   = {tag_q[lat_index_q], lat_index_q, cnt_q};
                    mem_writedata = data_q[lat_index_q][cnt_q];
                end else begin
                    mem_read    = !gap_q;
                    mem_address = {lat_tag_q, lat_index_q, cnt_q};
                end
                if (gap_q) begin
                    gap_d   = 1'b0;
                    first_d = 1'b1;
                end else if (first_q) begin
                    first_d = 1'b0;
                end else if (!bus.MEM_BUSYWAIT) begin
                    gap_d = 1'b1;
                    cnt_d = cnt_q + 2'd1;
                    // After the last fetch beat the UPDATE cycle doubles as the gap.
                    if (cnt_q == 2'd3) begin
                        state_d = (state_q == StWriteback) ? StFetch : StUpdate;
                    end
                end
            end
            StUpdate: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= StIdle;
            cnt_q      <= 2'd0;
            gap_q      <= 1'b0;
            first_q    <= 1'b0;
            valid_q    <= 8'h00;
            dirty_q    <= 8'h00;
            refilled_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            first_q <= first_d;
            if (idle_miss) begin
                lat_tag_q   <= tag_in;
                lat_index_q <= index;
                lat_wdata_q <= bus.CPU_WRITEDATA;
            end
            if (state_q == StUpdate) begin
                valid_q[lat_index_q] <= 1'b1;
                dirty_q[lat_index_q] <= 1'b0;
                tag_q[lat_index_q]   <= lat_tag_q;
                refilled_q           <= 1'b1;
            end
            if (idle_hit) begin
                refilled_q <= 1'b0;
                if (bus.CPU_WRITE) dirty_q[index] <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (idle_hit && bus.CPU_WRITE) begin
                data_q[index][offset] <= refilled_q ? lat_wdata_q : bus.CPU_WRITEDATA;
            end
            if (state_q == StFetch && beat_done) begin
                data_q[lat_index_q][cnt_q] <= bus.MEM_READDATA;
            end
        end
    end

    assign bus.MEM_READ      = mem_read;
    assign bus.MEM_WRITE     = mem_write;
    assign bus.MEM_ADDRESS   = mem_address;
    assign bus.MEM_WRITEDATA = mem_writedata;
    assign bus.CPU_BUSYWAIT  = (state_q != StIdle) || (req && !hit);
    // A simultaneous read and write is treated as a write, so no read data.
    assign bus.CPU_READDATA  = (idle_hit && !bus.CPU_WRITE) ? data_q[index][offset] : 8'h00;

`ifdef DCACHE_STATS_EN
    logic [7:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hit_cnt_q  <= 8'h00;
            miss_cnt_q <= 8'h00;
        end else begin
            if (idle_hit && !refilled_q && hit_cnt_q != 8'hFF) hit_cnt_q <= hit_cnt_q + 8'd1;
            if (idle_miss && miss_cnt_q != 8'hFF) miss_cnt_q <= miss_cnt_q + 8'd1;
        end
    end

    assign bus.HIT_COUNT  = hit_cnt_q;
    assign bus.MISS_COUNT = miss_cnt_q;
`endif
endmodule

// File: tb/tb_data_cache.sv
// Scoreboarded bench for data_cache: a byte memory model with programmable latency answers
// the cache, and a negedge monitor checks every completed beat and CPU access in order.
module tb_data_cache;
    typedef struct {
        int         kind;  // 0 mem read, 1 mem write, 2 cpu read, 3 cpu write
        logic [7:0] addr;
        logic [7:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_cache_if bus ();

    data_cache dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    ev_t        sb[$];
    int         total = 0;
    int         bad = 0;
    int         lat = 2;
    int         mem_cnt = 0;
    logic       mem_init = 1'b1;
    logic [7:0] mem [256];

    assign bus.MEM_READDATA = mem[bus.MEM_ADDRESS];
    assign bus.MEM_BUSYWAIT = (mem_cnt < lat - 1);

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
            mem_init <= 1'b0;
        end else if (bus.MEM_READ || bus.MEM_WRITE) begin
            if (!bus.MEM_BUSYWAIT) begin
                if (bus.MEM_WRITE) mem[bus.MEM_ADDRESS] <= bus.MEM_WRITEDATA;
                mem_cnt <= 0;
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end else begin
            mem_cnt <= 0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic observe(input int k, input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got kind=%0d addr=%02h data=%02h want none", k, a, d);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || e.addr != a || e.data != d) begin
                bad++;
                $display("FAIL event: got kind=%0d addr=%02h data=%02h want kind=%0d addr=%02h data=%02h",
                         k, a, d, e.kind, e.addr, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (bus.MEM_READ && bus.MEM_WRITE) begin
            total++;
            bad++;
            $display("FAIL mem_rw_both: got both high want exclusive");
        end
        if ((bus.MEM_READ || bus.MEM_WRITE) && !bus.MEM_BUSYWAIT) begin
            observe(bus.MEM_WRITE ? 1 : 0, bus.MEM_ADDRESS,
                    bus.MEM_WRITE ? bus.MEM_WRITEDATA : bus.MEM_READDATA);
        end
        if (!rst && (bus.CPU_READ || bus.CPU_WRITE) && !bus.CPU_BUSYWAIT) begin
            observe(bus.CPU_WRITE ? 3 : 2, bus.CPU_ADDRESS,
                    bus.CPU_WRITE ? bus.CPU_WRITEDATA : bus.CPU_READDATA);
        end
    end

    task automatic push(input int k, input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic push4(input int k, input logic [7:0] base, input logic [31:0] bytes);
        for (int i = 0; i < 4; i++) push(k, base + 8'(i), bytes[31 - 8 * i -: 8]);
    endtask

    task automatic cpu_op(input bit wr, input logic [7:0] a, input logic [7:0] wd,
                          input int exp_stall);
        int stall = 0;
        bit done = 1'b0;
        @(posedge clk);
        #1;
        bus.CPU_ADDRESS   = a;
        bus.CPU_WRITEDATA = wd;
        bus.CPU_READ      = !wr;
        bus.CPU_WRITE     = wr;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (!bus.CPU_BUSYWAIT) done = 1'b1;
            else stall++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL cpu_timeout: got busywait stuck at addr %02h want release", a);
        end
        check("stall_cycles", stall, exp_stall);
        @(posedge clk);
        #1;
        bus.CPU_READ  = 1'b0;
        bus.CPU_WRITE = 1'b0;
    endtask

    initial begin
        bit found = 1'b0;
        bus.CPU_ADDRESS   = 8'h00;
        bus.CPU_WRITEDATA = 8'h00;
        bus.CPU_READ      = 1'b0;
        bus.CPU_WRITE     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mem_read", int'(bus.MEM_READ), 0);
        check("rst_mem_write", int'(bus.MEM_WRITE), 0);
        check("rst_mem_address", int'(bus.MEM_ADDRESS), 0);
        check("rst_mem_writedata", int'(bus.MEM_WRITEDATA), 0);
        check("rst_cpu_busywait", int'(bus.CPU_BUSYWAIT), 0);
        check("rst_cpu_readdata", int'(bus.CPU_READDATA), 0);
`ifdef DCACHE_STATS_EN
        check("rst_hit_count", int'(bus.HIT_COUNT), 0);
        check("rst_miss_count", int'(bus.MISS_COUNT), 0);
`endif

        // Clean miss at 0x14, N=2: 4*(2+1)+1 stall cycles.
        push4(0, 8'h14, 32'h4E4F4C4D);
        push(2, 8'h14, 8'h4E);
        cpu_op(1'b0, 8'h14, 8'h00, 13);

        push(2, 8'h15, 8'h4F);
        cpu_op(1'b0, 8'h15, 8'h00, 0);

        push(3, 8'h16, 8'hAB);
        cpu_op(1'b1, 8'h16, 8'hAB, 0);

        // Dirty victim in line 5, N=3: 8*(3+1)+1 stall cycles.
        lat = 3;
        push4(1, 8'h14, 32'h4E4FAB4D);
        push4(0, 8'hB4, 32'hEEEFECED);
        push(2, 8'hB4, 8'hEE);
        cpu_op(1'b0, 8'hB4, 8'h00, 33);
        check("mem_writeback_16", int'(mem[8'h16]), 8'hAB);
`ifdef DCACHE_STATS_EN
        check("hit_count_4", int'(bus.HIT_COUNT), 2);
        check("miss_count_4", int'(bus.MISS_COUNT), 2);
`endif

        // Line 5 was clean after refill: no writeback, refill sees the stored 0xAB.
        lat = 2;
        push4(0, 8'h14, 32'h4E4FAB4D);
        push(2, 8'h16, 8'hAB);
        cpu_op(1'b0, 8'h16, 8'h00, 13);

        // Write miss allocates, then the line is dirty and is written back on eviction.
        push4(0, 8'h08, 32'h52535051);
        push(3, 8'h08, 8'h33);
        cpu_op(1'b1, 8'h08, 8'h33, 13);
        push(2, 8'h08, 8'h33);
        cpu_op(1'b0, 8'h08, 8'h00, 0);
        push4(1, 8'h08, 32'h33535051);
        push4(0, 8'h48, 32'h12131011);
        push(2, 8'h48, 8'h12);
        cpu_op(1'b0, 8'h48, 8'h00, 25);
        check("mem_writeback_08", int'(mem[8'h08]), 8'h33);

        // Reset in the first cycle of fetch beat 2 aborts the refill.
        push(0, 8'hB4, 8'hEE);
        push(0, 8'hB5, 8'hEF);
        @(posedge clk);
        #1;
        bus.CPU_ADDRESS = 8'hB4;
        bus.CPU_READ    = 1'b1;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus.MEM_READ && bus.MEM_ADDRESS == 8'hB6) found = 1'b1;
        end
        check("reach_fetch_beat2", int'(found), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.CPU_READ = 1'b0;
        check("abort_mem_read", int'(bus.MEM_READ), 0);
        check("abort_mem_write", int'(bus.MEM_WRITE), 0);
        @(negedge clk);
        check("abort_idle", int'(bus.CPU_BUSYWAIT), 0);
        push4(0, 8'hB4, 32'hEEEFECED);
        push(2, 8'hB4, 8'hEE);
        cpu_op(1'b0, 8'hB4, 8'h00, 13);
`ifdef DCACHE_STATS_EN
        check("hit_count_end", int'(bus.HIT_COUNT), 0);
        check("miss_count_end", int'(bus.MISS_COUNT), 1);
`endif

        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
